// File: rtl/game_pkg.sv
// Shared definitions for the dinosaur-runner game sequencer.
// Holds the FSM state encoding and the score/speed widths and limits
// used by game_ctrl and score_counter.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2,
    OVER = 2'd3
  } game_state_t;

  localparam int SCORE_W = 14;
  localparam int SPEED_W = 4;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

endpackage

// File: rtl/score_counter.sv
// Frame divider plus saturating score register.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   clear       synchronous clear of divider, score and step trackers
//   tick_en     count one frame tick this cycle
//   score       registered score, 0..SCORE_MAX
//   step_hit    high in the cycle whose edge moves score onto a nonzero
//               multiple of SPEED_STEP
//   hundred_hit high in the cycle whose edge moves score onto a nonzero
//               multiple of 100
//
// Both flags describe the increment about to be registered, so a consumer
// that registers on them updates on the same edge as the score itself.
module score_counter
  import game_pkg::*;
#(
  parameter int SCORE_DIV  = 6,
  parameter int SPEED_STEP = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               tick_en,
  output logic [SCORE_W-1:0] score,
  output logic               step_hit,
  output logic               hundred_hit
);

  localparam int DIV_W  = (SCORE_DIV  > 1) ? $clog2(SCORE_DIV)  : 1;
  localparam int STEP_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;

  logic [DIV_W-1:0]   div_q;
  logic [STEP_W-1:0]  step_q;
  logic [6:0]         hund_q;
  logic [SCORE_W-1:0] score_q;
  logic               wrap;
  logic               inc;

  // Side counters track score modulo SPEED_STEP and modulo 100 so the
  // milestone flags need no divider hardware. They advance only on a real
  // increment, so saturation at SCORE_MAX raises no further flags.
  assign wrap        = tick_en && (div_q == DIV_W'(SCORE_DIV - 1));
  assign inc         = wrap && (score_q != SCORE_MAX);
  assign step_hit    = inc && (step_q == STEP_W'(SPEED_STEP - 1));
  assign hundred_hit = inc && (hund_q == 7'd99);
  assign score       = score_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      step_q  <= '0;
      hund_q  <= '0;
      score_q <= '0;
    end else if (clear) begin
      div_q   <= '0;
      step_q  <= '0;
      hund_q  <= '0;
      score_q <= '0;
    end else begin
      if (tick_en) begin
        div_q <= wrap ? '0 : div_q + DIV_W'(1);
      end
      if (inc) begin
        score_q <= score_q + SCORE_W'(1);
        step_q  <= step_hit ? '0 : step_q + STEP_W'(1);
        hund_q  <= hundred_hit ? '0 : hund_q + 7'd1;
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Top-level game sequencer for the dinosaur runner.
// Runs the IDLE/RUN/DEAD/OVER state machine, turns frame ticks into a
// saturating score, ramps the scroll speed and requests buzzer beeps.
//
// Ports:
//   CLK          system clock
//   clrn         asynchronous active-low reset
//   frame_tick   one-cycle pulse per video frame
//   btn_jump     debounced jump button level
//   collision    dinosaur/obstacle overlap, sampled with frame_tick
//   game_status  1 only while running
//   state        current FSM state
//   speed        scroll speed
//   score        binary score, 0..9999
//   beep         buzzer request
module game_ctrl
  import game_pkg::*;
#(
  parameter int SCORE_DIV   = 6,
  parameter int SPEED_STEP  = 100,
  parameter int SPEED_INIT  = 1,
  parameter int SPEED_MAX   = 15,
  parameter int HOLD_FRAMES = 30,
  parameter int BEEP_FRAMES = 8
) (
  input  logic               CLK,
  input  logic               clrn,
  input  logic               frame_tick,
  input  logic               btn_jump,
  input  logic               collision,
  output logic               game_status,
  output logic [1:0]         state,
  output logic [SPEED_W-1:0] speed,
  output logic [SCORE_W-1:0] score,
  output logic               beep
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam int BEEP_W = $clog2(BEEP_FRAMES + 1);

  game_state_t        state_q, state_d;
  logic               btn_q;
  logic               press;
  logic               start;
  logic               collide;
  logic               tick_en;
  logic [HOLD_W-1:0]  hold_q;
  logic [BEEP_W-1:0]  beep_q;
  logic [SPEED_W-1:0] speed_q;
  logic               step_hit;
  logic               hundred_hit;

  // A press is a rising edge against the registered previous level, so a
  // held button counts once and a button held from RUN cannot restart.
  assign press = btn_jump && !btn_q;

  score_counter #(
    .SCORE_DIV  (SCORE_DIV),
    .SPEED_STEP (SPEED_STEP)
  ) u_score (
    .clk         (CLK),
    .rst_n       (clrn),
    .clear       (start),
    .tick_en     (tick_en),
    .score       (score),
    .step_hit    (step_hit),
    .hundred_hit (hundred_hit)
  );

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_jump;
    end
  end

  // Collision is checked before scoring, so a collision on a wrap tick
  // costs the point. A start clears the score counter, which outranks
  // any tick arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    collide = 1'b0;
    tick_en = 1'b0;
    unique case (state_q)
      IDLE, OVER: begin
        if (press) begin
          start   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (frame_tick) begin
          if (collision) begin
            collide = 1'b1;
            state_d = DEAD;
          end else begin
            tick_en = 1'b1;
          end
        end
      end
      DEAD: begin
        if (frame_tick && (hold_q == HOLD_W'(1))) begin
          state_d = OVER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      hold_q <= '0;
    end else if (collide) begin
      hold_q <= HOLD_W'(HOLD_FRAMES);
    end else if ((state_q == DEAD) && frame_tick && (hold_q != '0)) begin
      hold_q <= hold_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      speed_q <= SPEED_W'(SPEED_INIT);
    end else if (start) begin
      speed_q <= SPEED_W'(SPEED_INIT);
    end else if (step_hit && (speed_q < SPEED_W'(SPEED_MAX))) begin
      speed_q <= speed_q + SPEED_W'(1);
    end
  end

  // Reloads override the per-tick countdown; a start silences the buzzer.
  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      beep_q <= '0;
    end else if (start) begin
      beep_q <= '0;
    end else if (collide || hundred_hit) begin
      beep_q <= BEEP_W'(BEEP_FRAMES);
    end else if (frame_tick && (beep_q != '0)) begin
      beep_q <= beep_q - BEEP_W'(1);
    end
  end

  assign state       = state_q;
  assign game_status = (state_q == RUN);
  assign speed       = speed_q;
  assign beep        = (beep_q != '0);

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl. Two instances share the stimulus:
// one with default parameters and one with SCORE_DIV=1 for saturation.
module tb_game_ctrl;

  localparam int STEP     = 100;
  localparam int SPD_INIT = 1;
  localparam int SPD_MAX  = 15;
  localparam int HOLD     = 30;
  localparam int BEEPLEN  = 8;
  localparam int SMAX     = 9999;

  logic CLK = 1'b0;
  logic clrn;
  logic frameTick;
  logic btnJump;
  logic collision;

  logic        gs [2];
  logic [1:0]  st [2];
  logic [3:0]  sp [2];
  logic [13:0] sc [2];
  logic        bp [2];

  int checks = 0;
  int fails  = 0;

  int mState [2];
  int mScore [2];
  int mSpeed [2];
  int mDiv   [2];
  int mHold  [2];
  int mBeep  [2];
  bit mPrev  [2];
  int divOf  [2] = '{6, 1};

  always #5 CLK = ~CLK;

  game_ctrl dut (
    .CLK(CLK), .clrn(clrn), .frame_tick(frameTick), .btn_jump(btnJump),
    .collision(collision), .game_status(gs[0]), .state(st[0]),
    .speed(sp[0]), .score(sc[0]), .beep(bp[0])
  );

  game_ctrl #(.SCORE_DIV(1)) dutSat (
    .CLK(CLK), .clrn(clrn), .frame_tick(frameTick), .btn_jump(btnJump),
    .collision(collision), .game_status(gs[1]), .state(st[1]),
    .speed(sp[1]), .score(sc[1]), .beep(bp[1])
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mState[i] = 0; mScore[i] = 0; mSpeed[i] = SPD_INIT;
      mDiv[i] = 0; mHold[i] = 0; mBeep[i] = 0; mPrev[i] = 1'b0;
    end
  endtask

  // Game rules stated directly: score milestones come from the score value
  // itself by modulo arithmetic, states are plain integers.
  task automatic modelStep(input bit jump, input bit coll, input bit tick);
    bit press;
    for (int i = 0; i < 2; i++) begin
      press = jump && !mPrev[i];
      mPrev[i] = jump;
      if (tick && mBeep[i] > 0) mBeep[i]--;
      case (mState[i])
        0, 3: begin
          if (press) begin
            mState[i] = 1; mScore[i] = 0; mSpeed[i] = SPD_INIT;
            mDiv[i] = 0; mBeep[i] = 0;
          end
        end
        1: begin
          if (tick) begin
            if (coll) begin
              mState[i] = 2; mHold[i] = HOLD; mBeep[i] = BEEPLEN;
            end else begin
              mDiv[i]++;
              if (mDiv[i] == divOf[i]) begin
                mDiv[i] = 0;
                if (mScore[i] < SMAX) begin
                  mScore[i]++;
                  if (mScore[i] % 100 == 0) mBeep[i] = BEEPLEN;
                  if (mScore[i] % STEP == 0 && mSpeed[i] < SPD_MAX) mSpeed[i]++;
                end
              end
            end
          end
        end
        default: begin
          if (tick) begin
            mHold[i]--;
            if (mHold[i] == 0) mState[i] = 3;
          end
        end
      endcase
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("state%0d", i), st[i], mState[i]);
      checkOutput($sformatf("status%0d", i), gs[i], (mState[i] == 1) ? 1 : 0);
      checkOutput($sformatf("score%0d", i), sc[i], mScore[i]);
      checkOutput($sformatf("speed%0d", i), sp[i], mSpeed[i]);
      checkOutput($sformatf("beep%0d", i), bp[i], (mBeep[i] != 0) ? 1 : 0);
    end
  endtask

  // Drive one cycle of inputs from the falling edge, then check after the
  // following falling edge, well away from the active edge.
  task automatic applyStimulus(input bit jump, input bit coll, input bit tick);
    btnJump = jump; collision = coll; frameTick = tick;
    @(posedge CLK);
    modelStep(jump, coll, tick);
    @(negedge CLK);
    checkAll();
  endtask

  task automatic frameTicks(input int n, input int maxGap, input bit noisy, input bit level);
    int gap;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(maxGap, 0);
      for (int g = 0; g < gap; g++)
        applyStimulus(noisy ? 1'($urandom_range(1, 0)) : level, 1'($urandom_range(1, 0)), 1'b0);
      applyStimulus(noisy ? 1'($urandom_range(1, 0)) : level, 1'b0, 1'b1);
    end
  endtask

  task automatic pressButton();
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulled between edges; outputs must clear at once.
  task automatic doReset();
    #2 clrn = 1'b0;
    #1 modelReset();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rst_state%0d", i), st[i], 0);
      checkOutput($sformatf("rst_score%0d", i), sc[i], 0);
      checkOutput($sformatf("rst_speed%0d", i), sp[i], SPD_INIT);
      checkOutput($sformatf("rst_status%0d", i), gs[i], 0);
      checkOutput($sformatf("rst_beep%0d", i), bp[i], 0);
    end
    @(negedge CLK);
    clrn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    clrn = 1'b1; frameTick = 1'b0; btnJump = 1'b0; collision = 1'b0;
    @(negedge CLK);
    doReset();

    $display("[TB] basic scoring, start coinciding with a tick");
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("start_state", st[0], 1);
    checkOutput("start_score", sc[0], 0);
    frameTicks(60, 2, 1'b0, 1'b0);
    checkOutput("basic_state", st[0], 1);
    checkOutput("basic_score", sc[0], 10);
    checkOutput("basic_speed", sp[0], 1);
    checkOutput("basic_beep", bp[0], 0);

    $display("[TB] reset mid-game");
    frameTicks(40, 1, 1'b1, 1'b0);
    doReset();

    $display("[TB] speed step and milestone beep");
    pressButton();
    frameTicks(600, 1, 1'b1, 1'b0);
    checkOutput("step_score", sc[0], 100);
    checkOutput("step_speed", sp[0], 2);
    checkOutput("step_beep_on", bp[0], 1);
    frameTicks(7, 1, 1'b1, 1'b0);
    checkOutput("step_beep_7", bp[0], 1);
    frameTicks(1, 1, 1'b1, 1'b0);
    checkOutput("step_beep_off", bp[0], 0);

    $display("[TB] collision, hold and restart");
    doReset();
    pressButton();
    frameTicks(5, 2, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("coll_state", st[0], 2);
    checkOutput("coll_score", sc[0], 0);
    checkOutput("coll_beep", bp[0], 1);
    frameTicks(7, 1, 1'b1, 1'b0);
    checkOutput("coll_beep_7", bp[0], 1);
    frameTicks(1, 1, 1'b1, 1'b0);
    checkOutput("coll_beep_off", bp[0], 0);
    frameTicks(21, 1, 1'b1, 1'b0);
    checkOutput("hold_state", st[0], 2);
    frameTicks(1, 0, 1'b0, 1'b0);
    checkOutput("over_state", st[0], 3);
    pressButton();
    checkOutput("restart_state", st[0], 1);
    checkOutput("restart_score", sc[0], 0);
    checkOutput("restart_speed", sp[0], 1);

    $display("[TB] button held through death");
    frameTicks(3, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    frameTicks(30, 1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("held_state", st[0], 3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("repress_state", st[0], 1);

    $display("[TB] saturation");
    doReset();
    pressButton();
    frameTicks(1399, 0, 1'b0, 1'b0);
    checkOutput("sat_score_1399", sc[1], 1399);
    checkOutput("sat_speed_14", sp[1], 14);
    frameTicks(1, 0, 1'b0, 1'b0);
    checkOutput("sat_speed_15", sp[1], 15);
    frameTicks(8500, 0, 1'b0, 1'b0);
    checkOutput("sat_score_9900", sc[1], 9900);
    checkOutput("sat_beep_9900", bp[1], 1);
    frameTicks(99, 0, 1'b0, 1'b0);
    checkOutput("sat_score_max", sc[1], 9999);
    frameTicks(101, 0, 1'b0, 1'b0);
    checkOutput("sat_score_hold", sc[1], 9999);
    checkOutput("sat_speed_hold", sp[1], 15);
    checkOutput("sat_beep_quiet", bp[1], 0);
    checkOutput("sat_state", st[1], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
